// File: rtl/ks_msg_sched.sv
// Two-port round-robin message scheduler feeding the per-string message bus of the ks string bank.
// Optional per-string pluck hold-off is compiled in with `define KS_SCHED_HOLDOFF_EN.
module ks_msg_sched #(
  parameter int NSTR    = 6,
  parameter int DEPTH   = 8,
  parameter int HOLDOFF = 64
) (
  input  logic            lrck,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [2:0]      a_str,
  input  logic [8:0]      a_addr,
  input  logic [31:0]     a_msg,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [2:0]      b_str,
  input  logic [8:0]      b_addr,
  input  logic [31:0]     b_msg,
  input  logic            panic_all,
  output logic [NSTR-1:0] msg_en,
  output logic [8:0]      msg_addr,
  output logic [31:0]     msg,
  output logic [3:0]      fifo_level,
  output logic            err_badstr,
  output logic [7:0]      pluck_supp
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         EW      = 3 + 9 + 32;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);
  localparam logic [3:0] NSTR_L  = 4'(NSTR);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    level_q, level_d;
  logic          favour_b_q, favour_b_d;
  logic          err_q, err_d;

  logic [NSTR-1:0] en_q, en_d;
  logic [8:0]      addr_q, addr_d;
  logic [31:0]     msg_q, msg_d;

  logic        full, empty;
  logic        grant_a, grant_b;
  logic        xfer_a, xfer_b, xfer;
  logic [2:0]  sel_str;
  logic [8:0]  sel_addr;
  logic [31:0] sel_msg;
  logic        str_ok;
  logic        push, pop;

  logic [EW-1:0] head;
  logic [2:0]    head_str;
  logic [8:0]    head_addr;
  logic [31:0]   head_msg;
  logic          issue_pluck;

  // Handshake: a requester raises valid and holds it with a stable payload until it
  // sees ready high at a posedge; that edge is the transfer. Ready is combinational
  // and only ever granted to one port at a time.
  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == 4'd0);
  assign grant_a = a_valid & (~b_valid | ~favour_b_q);
  assign grant_b = b_valid & (~a_valid | favour_b_q);
  assign a_ready = rst_n & ~full & grant_a;
  assign b_ready = rst_n & ~full & grant_b;
  assign xfer_a  = a_valid & a_ready;
  assign xfer_b  = b_valid & b_ready;
  assign xfer    = xfer_a | xfer_b;

  assign sel_str  = xfer_b ? b_str  : a_str;
  assign sel_addr = xfer_b ? b_addr : a_addr;
  assign sel_msg  = xfer_b ? b_msg  : a_msg;
  assign str_ok   = ({1'b0, sel_str} < NSTR_L);

  assign push = xfer & str_ok;
  assign pop  = ~panic_all & ~empty;

  assign head      = mem_q[rd_ptr_q];
  assign head_str  = head[43:41];
  assign head_addr = head[40:32];
  assign head_msg  = head[31:0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    favour_b_d = favour_b_q;
    err_d      = err_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      level_d = level_q + 4'd1;
    else if (pop && !push) level_d = level_q - 4'd1;
    if (xfer_a) favour_b_d = 1'b1;
    if (xfer_b) favour_b_d = 1'b0;
    if (xfer && !str_ok) err_d = 1'b1;
  end

  always_ff @(posedge lrck) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 4'd0;
      favour_b_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      favour_b_q <= favour_b_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge lrck) begin
    if (push) mem_q[wr_ptr_q] <= {sel_str, sel_addr, sel_msg};
  end

`ifdef KS_SCHED_HOLDOFF_EN
  localparam int            CW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);

  logic [CW-1:0] hold_q [NSTR];
  logic [CW-1:0] hold_d [NSTR];
  logic [7:0]    supp_q, supp_d;
  logic          head_busy;

  always_comb begin
    head_busy = 1'b0;
    for (int i = 0; i < NSTR; i++) begin
      if ((head_str == 3'(i)) && (hold_q[i] != '0)) head_busy = 1'b1;
    end
  end

  // A suppressed pluck still issues (bit 0 cleared) and does not restart the window.
  always_comb begin
    supp_d = supp_q;
    for (int i = 0; i < NSTR; i++) begin
      hold_d[i] = (hold_q[i] != '0) ? (hold_q[i] - CW'(1)) : '0;
    end
    if (panic_all) begin
      for (int i = 0; i < NSTR; i++) hold_d[i] = '0;
    end else if (pop && head_msg[0]) begin
      if (head_busy) begin
        if (supp_q != 8'hFF) supp_d = supp_q + 8'd1;
      end else begin
        for (int i = 0; i < NSTR; i++) begin
          if (head_str == 3'(i)) hold_d[i] = HOLD_LOAD;
        end
      end
    end
  end

  always_ff @(posedge lrck) begin
    if (!rst_n) begin
      supp_q <= 8'd0;
      for (int i = 0; i < NSTR; i++) hold_q[i] <= '0;
    end else begin
      supp_q <= supp_d;
      for (int i = 0; i < NSTR; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign issue_pluck = head_msg[0] & ~head_busy;
  assign pluck_supp  = supp_q;
`else
  assign issue_pluck = head_msg[0];
  assign pluck_supp  = 8'd0;
`endif

  // Panic outranks the queue and leaves it untouched; an idle cycle keeps addr/msg.
  always_comb begin
    en_d   = '0;
    addr_d = addr_q;
    msg_d  = msg_q;
    if (panic_all) begin
      en_d   = '1;
      addr_d = 9'd0;
      msg_d  = 32'h0000_0002;
    end else if (pop) begin
      for (int i = 0; i < NSTR; i++) en_d[i] = (head_str == 3'(i));
      addr_d = head_addr;
      msg_d  = {head_msg[31:1], issue_pluck};
    end
  end

  always_ff @(posedge lrck) begin
    if (!rst_n) begin
      en_q   <= '0;
      addr_q <= 9'd0;
      msg_q  <= 32'd0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      msg_q  <= msg_d;
    end
  end

  assign msg_en     = en_q;
  assign msg_addr   = addr_q;
  assign msg        = msg_q;
  assign fifo_level = level_q;
  assign err_badstr = err_q;

endmodule

// File: tb/tb_ks_msg_sched.sv
// Directed plus randomized bench for ks_msg_sched, checked against a transaction-level
// model (message queue, last-granted port, per-string time of last passed pluck).
module tb_ks_msg_sched;
  localparam int NSTR    = 6;
  localparam int DEPTH   = 8;
  localparam int HOLDOFF = 4;
  localparam int EW      = 44;

  // clock / reset
  logic lrck  = 1'b0;
  logic rst_n = 1'b0;
  always #5 lrck = ~lrck;

  logic            a_valid = 1'b0, b_valid = 1'b0;
  logic            a_ready, b_ready;
  logic [2:0]      a_str = '0, b_str = '0;
  logic [8:0]      a_addr = '0, b_addr = '0;
  logic [31:0]     a_msg = '0, b_msg = '0;
  logic            panic_all = 1'b0;
  logic [NSTR-1:0] msg_en;
  logic [8:0]      msg_addr;
  logic [31:0]     msg;
  logic [3:0]      fifo_level;
  logic            err_badstr;
  logic [7:0]      pluck_supp;

  ks_msg_sched #(.NSTR(NSTR), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .lrck(lrck), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_str(a_str), .a_addr(a_addr), .a_msg(a_msg),
    .b_valid(b_valid), .b_ready(b_ready), .b_str(b_str), .b_addr(b_addr), .b_msg(b_msg),
    .panic_all(panic_all),
    .msg_en(msg_en), .msg_addr(msg_addr), .msg(msg),
    .fifo_level(fifo_level), .err_badstr(err_badstr), .pluck_supp(pluck_supp)
  );

  // scoreboard / reference model
  int              checks = 0;
  int              passed = 0;
  logic [EW-1:0]   exp_q[$];
  logic            last_was_b;
  logic            err_m;
  logic [7:0]      supp_m;
  logic [NSTR-1:0] en_m;
  logic [8:0]      addr_m;
  logic [31:0]     msg_m;
  longint          cyc = 0;
  longint          last_pass[NSTR];
  logic            xa = 1'b0, xb = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_was_b = 1'b1;
    err_m  = 1'b0;
    supp_m = 8'd0;
    en_m   = '0;
    addr_m = '0;
    msg_m  = '0;
    foreach (last_pass[i]) last_pass[i] = -1000;
  endtask

  // One lrck cycle: readies checked mid-cycle, registered outputs 1 time unit after the edge.
  task automatic cycle();
    logic          ra, rb, full;
    logic [EW-1:0] e;
    int            s;
    @(negedge lrck);
    full = (exp_q.size() == DEPTH);
    ra = rst_n && !full && a_valid && (!b_valid || last_was_b);
    rb = rst_n && !full && b_valid && (!a_valid || !last_was_b);
    chk("a_ready", 32'(a_ready), 32'(ra));
    chk("b_ready", 32'(b_ready), 32'(rb));
    xa = a_valid && ra;
    xb = b_valid && rb;
    @(posedge lrck);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (panic_all) begin
        en_m = '1; addr_m = '0; msg_m = 32'h2;
        foreach (last_pass[i]) last_pass[i] = -1000;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        s = int'(e[43:41]);
        en_m = '0; en_m[s] = 1'b1;
        addr_m = e[40:32];
        msg_m  = e[31:0];
`ifdef KS_SCHED_HOLDOFF_EN
        if (msg_m[0]) begin
          if (cyc - last_pass[s] < HOLDOFF) begin
            msg_m[0] = 1'b0;
            if (supp_m != 8'hFF) supp_m++;
          end else begin
            last_pass[s] = cyc;
          end
        end
`endif
      end else begin
        en_m = '0;
      end
      if (xa || xb) begin
        e = xb ? {b_str, b_addr, b_msg} : {a_str, a_addr, a_msg};
        last_was_b = xb;
        if (int'(e[43:41]) >= NSTR) err_m = 1'b1;
        else exp_q.push_back(e);
      end
    end
    #1;
    chk("msg_en", 32'(msg_en), 32'(en_m));
    chk("msg_addr", 32'(msg_addr), 32'(addr_m));
    chk("msg", msg, msg_m);
    chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("err_badstr", 32'(err_badstr), 32'(err_m));
    chk("pluck_supp", 32'(pluck_supp), 32'(supp_m));
  endtask

  // driver tasks
  task automatic send(input bit port_b, input logic [2:0] s, input logic [8:0] ad,
                      input logic [31:0] m);
    bit done = 1'b0;
    if (port_b) begin b_valid = 1'b1; b_str = s; b_addr = ad; b_msg = m; end
    else begin a_valid = 1'b1; a_str = s; a_addr = ad; a_msg = m; end
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      done = port_b ? xb : xa;
    end
    if (port_b) b_valid = 1'b0;
    else a_valid = 1'b0;
    if (!done) begin
      checks++;
      $error("FAIL send_timeout observed=no_transfer expected=transfer");
    end
  endtask

  function automatic logic [EW-1:0] rand_ok();
    logic [EW-1:0] e;
    e = {3'($urandom_range(0, NSTR - 1)), 9'($urandom), 32'($urandom)};
    e[0] = 1'b0;
    return e;
  endfunction

  initial begin
    int n;
    model_reset();

    // reset with both requesters active
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
    cycle();
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_en", 32'(msg_en), 32'd0);

    // single issue
    send(1'b0, 3'd2, 9'o123, 32'h8040_1001);
    cycle();
    chk("single_en", 32'(msg_en), 32'b000100);
    chk("single_addr", 32'(msg_addr), 32'o123);
    chk("single_msg", msg, 32'h8040_1001);
    chk("single_level", 32'(fifo_level), 32'd0);
    cycle();
    chk("single_strobe_once", 32'(msg_en), 32'd0);

    // round-robin into a full FIFO while panic blocks draining
    panic_all = 1'b1;
    a_valid = 1'b1; {a_str, a_addr, a_msg} = rand_ok();
    b_valid = 1'b1; {b_str, b_addr, b_msg} = rand_ok();
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (xa) {a_str, a_addr, a_msg} = rand_ok();
      if (xb) {b_str, b_addr, b_msg} = rand_ok();
    end
    chk("full_level", 32'(fifo_level), 32'(DEPTH));
    chk("full_a_ready", 32'(a_ready), 32'd0);
    chk("full_b_ready", 32'(b_ready), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0; panic_all = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (msg_en != '0) n++;
    end
    chk("drain_strobes", 32'(n), 32'd8);
    chk("drain_level", 32'(fifo_level), 32'd0);

    // bad string index
    send(1'b1, 3'd7, 9'd1, 32'h0000_0100);
    chk("badstr_level", 32'(fifo_level), 32'd0);
    chk("badstr_flag", 32'(err_badstr), 32'd1);
    cycle();
    cycle();
    chk("badstr_sticky", 32'(err_badstr), 32'd1);

    // panic with messages queued behind it
    panic_all = 1'b1;
    send(1'b0, 3'd3, 9'd11, 32'h0000_0A00);
    chk("panic_en", 32'(msg_en), 32'h3F);
    chk("panic_msg", msg, 32'h2);
    chk("panic_addr", 32'(msg_addr), 32'd0);
    send(1'b1, 3'd4, 9'd22, 32'h0000_0B00);
    send(1'b0, 3'd5, 9'd33, 32'h0000_0C00);
    chk("panic_hold_level", 32'(fifo_level), 32'd3);
    panic_all = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (msg_en != '0) n++;
    end
    chk("panic_release_strobes", 32'(n), 32'd3);
    chk("panic_last_msg", msg, 32'h0000_0C00);

    // pluck hold-off: plucks to string 1 issue at T, T+2, T+4
    send(1'b0, 3'd1, 9'd5, 32'h0000_0011);
    cycle();
    send(1'b0, 3'd1, 9'd6, 32'h0000_0021);
    cycle();
`ifdef KS_SCHED_HOLDOFF_EN
    chk("holdoff_t2_pluck", 32'(msg[0]), 32'd0);
    chk("holdoff_t2_supp", 32'(pluck_supp), 32'd1);
`else
    chk("holdoff_t2_pluck", 32'(msg[0]), 32'd1);
    chk("holdoff_t2_supp", 32'(pluck_supp), 32'd0);
`endif
    send(1'b0, 3'd1, 9'd7, 32'h0000_0031);
    cycle();
    chk("holdoff_t4_pluck", 32'(msg[0]), 32'd1);

    // randomized traffic with panic pulses and one mid-run reset
    for (int c = 0; c < 400; c++) begin
      rst_n = (c != 250);
      panic_all = ($urandom_range(0, 15) == 0);
      if (!a_valid || xa) begin
        a_valid = ($urandom_range(0, 9) < 6);
        a_str = 3'($urandom_range(0, 7)); a_addr = 9'($urandom); a_msg = 32'($urandom);
      end
      if (!b_valid || xb) begin
        b_valid = ($urandom_range(0, 9) < 6);
        b_str = 3'($urandom_range(0, 7)); b_addr = 9'($urandom); b_msg = 32'($urandom);
      end
      cycle();
    end

    // final reset returns everything to zero
    a_valid = 1'b0; b_valid = 1'b0; panic_all = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("final_err", 32'(err_badstr), 32'd0);
    chk("final_level", 32'(fifo_level), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
